// File: rtl/rr_arbiter_5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_5_pkg
// Brief    : Shared constants, FSM state encoding and pointer helper for the
//            5-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter_5_pkg;

  localparam int NUM_REQ = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Search start for the next arbitration: one past the new owner, wrapping 4->0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_enc_5to3.sv
`default_nettype none
// ============================================================================
// Module   : onehot_enc_5to3
// Brief    : One-hot to binary encoder, 5 inputs to 3-bit index.
//            An all-zero input encodes to 3'h0.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_enc_5to3 (
  input  logic [4:0] onehot,
  output logic [2:0] idx
);

  // OR-tree encode; valid for one-hot or zero inputs only.
  always_comb begin
    idx[0] = onehot[1] | onehot[3];
    idx[1] = onehot[2] | onehot[3];
    idx[2] = onehot[4];
  end

endmodule
`default_nettype wire

// File: rtl/rr_pick_5.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_5
// Brief    : Combinational rotating-priority select. Searches req starting at
//            ptr and wrapping modulo 5; returns the first set bit as a one-hot
//            winner and its index. Zero req gives a zero winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_5
  import rr_arbiter_5_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  logic [IDX_W:0] w_pos;
  logic           w_found;

  // Walk the five positions in priority order from ptr; first hit wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_found && req[w_pos[IDX_W-1:0]]) begin
        w_found               = 1'b1;
        win[w_pos[IDX_W-1:0]] = 1'b1;
        win_idx               = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_5.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_5
// Brief    : 5-way round-robin arbiter with registered one-hot grant, binary
//            grant index and grant-valid. One dead (GAP) cycle between owners.
//            Optional macro RR_ARB_HOLD_LIMIT_EN: force release after HOLD_MAX
//            consecutive grant cycles when another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_5
  import rr_arbiter_5_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_win;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_hold_release;

  // A hold limit below 2 cycles would make the counter meaningless.
  if (HOLD_MAX < 2) begin : g_hold_max_chk
    $error("rr_arbiter_5: HOLD_MAX must be at least 2");
  end

  rr_pick_5 u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  onehot_enc_5to3 u_enc (
    .onehot (r_gnt),
    .idx    (gnt_idx)
  );

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int              HOLD_W      = $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] r_hold_cnt;

  // Release only matters when someone else is waiting; a sole owner keeps it.
  assign w_hold_release = (r_hold_cnt == c_HOLD_LAST) && (|(req & ~r_gnt));

  // Count owner tenure: clear on each new grant, saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state != ST_BUSY && (|req)) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_BUSY && r_hold_cnt != c_HOLD_LAST) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  assign w_hold_release = 1'b0;
`endif

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state: IDLE and GAP arbitrate alike; BUSY holds until the owner drops.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          w_gnt_nxt   = w_win;
          w_ptr_nxt   = next_ptr(w_win_idx);
          w_state_nxt = ST_BUSY;
        end else begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!(|(req & r_gnt)) || w_hold_release) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
